ahb_debug_mailbox: RTL and testbench

AHB-Lite slave implementing the two simulation debug registers at the top of the user address space (HADDR[23:0] = 24'hFFFFF8 / 24'hFFFFFC).
- DBG0: byte-addressable scratch/status register, mirrored to a side output.
- DBG1: message port. Each firmware write is queued in a small FIFO, which the cocotb bench drains through a valid/ready stream.
- Sits directly downstream of the user wrapper's AHB address split. Drives the HRDATA_debug path.

---
 rtl/ahb_dbg_pkg.sv | 34 +++
 rtl/ahb_debug_mailbox_if.sv | 23 ++
 rtl/dbg_msg_fifo.sv | 63 ++++++
 rtl/ahb_debug_mailbox.sv | 144 ++++++++++++++
 tb/tb_ahb_debug_mailbox.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ahb_dbg_pkg.sv
// Shared constants, select type and byte-lane helper for the AHB debug mailbox.
package ahb_dbg_pkg;

    localparam logic [23:0] DBG0_OFF = 24'hFFFFF8;
    localparam logic [23:0] DBG1_OFF = 24'hFFFFFC;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_DBG0 = 2'd1,
        SEL_DBG1 = 2'd2
    } sel_e;

    // Sizes wider than a word are treated as a full-word write.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] lanes;
        lanes = 4'b1111;
        if (size == HSIZE_BYTE) begin
            lanes = 4'b0001 << addr;
        end else if (size == HSIZE_HALF) begin
            lanes = addr[1] ? 4'b1100 : 4'b0011;
        end
        return lanes;
    endfunction

endpackage

// File: rtl/ahb_debug_mailbox_if.sv
// AHB-Lite bus signals seen by the debug mailbox slave.
interface ahb_debug_mailbox_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/dbg_msg_fifo.sv
// Circular message FIFO with occupancy count; head is registered, no fall-through.
module dbg_msg_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_MAX);
    assign o_count   = r_count;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/ahb_debug_mailbox.sv
// AHB-Lite slave with a byte-addressable scratch register (DBG0) and a message FIFO port (DBG1).
module ahb_debug_mailbox
    import ahb_dbg_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    ahb_debug_mailbox_if.slave        bus,
    output logic [31:0]               dbg0_o,
    output logic                      msg_valid,
    output logic [31:0]               msg_data,
    input  logic                      msg_ready,
    output logic                      msg_overflow
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             r_wr;
    sel_e             r_sel;
    logic [2:0]       r_size;
    logic [1:0]       r_addr;
    logic [31:0]      r_dbg0;
    logic [31:0]      r_hrdata;
    logic             r_ovf;

    logic             w_accept;
    sel_e             w_sel_dec;
    logic [3:0]       w_lanes;
    logic             w_dbg0_we;
    logic [31:0]      w_dbg0_next;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_ovf_clr;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [31:0]      w_dbg1_rd;
    logic             w_unused;

    assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign w_unused = &{1'b0, bus.HADDR[31:24], bus.HTRANS[0]};

    always_comb begin
        w_sel_dec = SEL_NONE;
        if (bus.HADDR[23:2] == DBG0_OFF[23:2]) begin
            w_sel_dec = SEL_DBG0;
        end else if (bus.HADDR[23:2] == DBG1_OFF[23:2]) begin
            w_sel_dec = SEL_DBG1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr   <= 1'b0;
            r_sel  <= SEL_NONE;
            r_size <= '0;
            r_addr <= '0;
        end else if (w_accept) begin
            r_wr   <= bus.HWRITE;
            r_sel  <= w_sel_dec;
            r_size <= bus.HSIZE;
            r_addr <= bus.HADDR[1:0];
        end else begin
            r_sel  <= SEL_NONE;
        end
    end

    assign w_lanes   = byte_lanes(r_size, r_addr);
    assign w_dbg0_we = r_wr && (r_sel == SEL_DBG0);

    always_comb begin
        w_dbg0_next = r_dbg0;
        if (w_dbg0_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_lanes[i]) begin
                    w_dbg0_next[8*i +: 8] = bus.HWDATA[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dbg0 <= '0;
        end else begin
            r_dbg0 <= w_dbg0_next;
        end
    end

    assign w_push    = r_wr && (r_sel == SEL_DBG1);
    assign w_pop     = msg_ready & ~w_empty;
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_ovf_clr = !r_wr && (r_sel == SEL_DBG1);

    dbg_msg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .i_push  (w_push),
        .i_data  (bus.HWDATA),
        .i_pop   (w_pop),
        .o_data  (msg_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A drop in the same cycle as a clearing read keeps the flag set.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_drop | (r_ovf & ~w_ovf_clr);
        end
    end

    assign w_dbg1_rd = {16'b0, 7'b0, r_ovf, 8'(w_count)};

    // Read data is captured at address acceptance; DBG0 forwards a write landing this cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hrdata <= '0;
        end else if (w_accept && !bus.HWRITE) begin
            case (w_sel_dec)
                SEL_DBG0: r_hrdata <= w_dbg0_next;
                SEL_DBG1: r_hrdata <= w_dbg1_rd;
                default:  r_hrdata <= '0;
            endcase
        end else begin
            r_hrdata <= '0;
        end
    end

    assign bus.HRDATA    = r_hrdata;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
    assign dbg0_o        = r_dbg0;
    assign msg_valid     = ~w_empty;
    assign msg_overflow  = r_ovf;

endmodule

// File: tb/tb_ahb_debug_mailbox.sv
// Directed self-checking bench for ahb_debug_mailbox.
module tb_ahb_debug_mailbox;
    import ahb_dbg_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] dbg0_o;
    logic        msg_valid;
    logic [31:0] msg_data;
    logic        msg_ready;
    logic        msg_overflow;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    localparam logic [31:0] A_DBG0  = 32'h00FFFFF8;
    localparam logic [31:0] A_DBG0B = 32'h00FFFFF9;
    localparam logic [31:0] A_DBG0H = 32'h00FFFFFA;
    localparam logic [31:0] A_DBG1  = 32'h00FFFFFC;

    ahb_debug_mailbox_if bus ();

    ahb_debug_mailbox #(.FIFO_DEPTH(4)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .bus          (bus),
        .dbg0_o       (dbg0_o),
        .msg_valid    (msg_valid),
        .msg_data     (msg_data),
        .msg_ready    (msg_ready),
        .msg_overflow (msg_overflow)
    );

    always #5 HCLK = ~HCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus cycle: address-phase fields plus write data for the previous transfer.
    task automatic cyc(input logic s, input logic [1:0] t, input logic w, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
        bus.HSEL   = s;
        bus.HTRANS = t;
        bus.HWRITE = w;
        bus.HSIZE  = sz;
        bus.HADDR  = a;
        bus.HWDATA = wd;
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input logic [31:0] wd);
        cyc(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, wd);
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, sz, a, 32'h0);
        idle(d);
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, a, 32'h0);
        d = bus.HRDATA;
        idle(32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_q [4];

        HRESETn    = 1'b0;
        msg_ready  = 1'b0;
        bus.HREADY = 1'b1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = HSIZE_WORD;
        bus.HADDR  = 32'h0;
        bus.HWDATA = 32'h0;
        repeat (3) @(posedge HCLK);
        #1;
        check_val("rst_hrdata", bus.HRDATA, 32'h0);
        check_val("rst_dbg0", dbg0_o, 32'h0);
        check_val("rst_valid", {31'b0, msg_valid}, 32'h0);
        check_val("rst_ovf", {31'b0, msg_overflow}, 32'h0);
        check_val("rst_msgdata", msg_data, 32'h0);
        check_val("rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'h1);
        check_val("rst_hresp", {31'b0, bus.HRESP}, 32'h0);
        HRESETn = 1'b1;
        idle(32'h0);

        // Pipelined word write, byte write, then read of DBG0.
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, A_DBG0, 32'h0);
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, A_DBG0B, 32'hDEADBEEF);
        check_val("dbg0_word", dbg0_o, 32'hDEADBEEF);
        cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, A_DBG0, 32'h00005500);
        check_val("dbg0_byte", dbg0_o, 32'hDEAD55EF);
        check_val("rd_b2b", bus.HRDATA, 32'hDEAD55EF);
        idle(32'h0);

        ahb_write(A_DBG0H, HSIZE_HALF, 32'h12340000);
        check_val("dbg0_half", dbg0_o, 32'h123455EF);
        ahb_read(A_DBG0, rd);
        check_val("rd_dbg0", rd, 32'h123455EF);

        // Non-accepted transfers and unmapped addresses leave state alone.
        cyc(1'b1, HTRANS_IDLE, 1'b1, HSIZE_WORD, A_DBG0, 32'h0);
        idle(32'hFFFFFFFF);
        check_val("idle_trans", dbg0_o, 32'h123455EF);
        cyc(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, A_DBG0, 32'h0);
        idle(32'hFFFFFFFF);
        check_val("hsel_low", dbg0_o, 32'h123455EF);
        ahb_write(32'h00FFFFF0, HSIZE_WORD, 32'hA5A5A5A5);
        check_val("other_wr_dbg0", dbg0_o, 32'h123455EF);
        check_val("other_wr_valid", {31'b0, msg_valid}, 32'h0);
        ahb_read(32'h00000100, rd);
        check_val("other_rd", rd, 32'h0);

        // Fill FIFO, overflow, and clear-on-read.
        for (int i = 1; i <= 4; i++) begin
            ahb_write(A_DBG1, HSIZE_WORD, 32'(i));
        end
        check_val("fill_valid", {31'b0, msg_valid}, 32'h1);
        check_val("fill_head", msg_data, 32'h1);
        ahb_read(A_DBG1, rd);
        check_val("rd_dbg1_full", rd, 32'h00000004);
        ahb_write(A_DBG1, HSIZE_WORD, 32'h5);
        check_val("ovf_set", {31'b0, msg_overflow}, 32'h1);
        ahb_read(A_DBG1, rd);
        check_val("rd_dbg1_ovf", rd, 32'h00000104);
        check_val("ovf_clr", {31'b0, msg_overflow}, 32'h0);
        ahb_read(A_DBG1, rd);
        check_val("rd_dbg1_after", rd, 32'h00000004);

        // Drain one per cycle.
        msg_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_val("drain_valid", {31'b0, msg_valid}, 32'h1);
            check_val("drain_data", msg_data, 32'(i));
            @(posedge HCLK);
            #1;
        end
        check_val("drain_empty", {31'b0, msg_valid}, 32'h0);
        msg_ready = 1'b0;
        ahb_read(A_DBG1, rd);
        check_val("rd_dbg1_empty", rd, 32'h0);

        // Push into a full FIFO while popping the head.
        for (int i = 1; i <= 4; i++) begin
            ahb_write(A_DBG1, HSIZE_WORD, 32'(i));
        end
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, A_DBG1, 32'h0);
        msg_ready = 1'b1;
        idle(32'h9);
        msg_ready = 1'b0;
        check_val("full_pp_ovf", {31'b0, msg_overflow}, 32'h0);
        ahb_read(A_DBG1, rd);
        check_val("full_pp_cnt", rd, 32'h00000004);
        exp_q = '{32'h2, 32'h3, 32'h4, 32'h9};
        msg_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("pp_drain", msg_data, exp_q[i]);
            @(posedge HCLK);
            #1;
        end
        check_val("pp_empty", {31'b0, msg_valid}, 32'h0);
        msg_ready = 1'b0;

        // Reset during a DBG1 write data phase.
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, A_DBG1, 32'h0);
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWDATA = 32'hAA;
        #2;
        HRESETn = 1'b0;
        #1;
        check_val("rst_mid_hreadyout", {31'b0, bus.HREADYOUT}, 32'h1);
        check_val("rst_mid_dbg0", dbg0_o, 32'h0);
        @(posedge HCLK);
        #1;
        check_val("rst_mid_valid", {31'b0, msg_valid}, 32'h0);
        HRESETn = 1'b1;
        repeat (3) idle(32'h0);
        check_val("post_rst_valid", {31'b0, msg_valid}, 32'h0);
        ahb_read(A_DBG1, rd);
        check_val("post_rst_cnt", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
